aes_key_expansion: RTL and testbench

- AES-128 key schedule stage, directly upstream of the AES encryption core.
- Captures a 128-bit cipher key on start and computes round keys 0..10, one round per clock.
- Stores all 11 round keys and flags completion on key_expansion_done.
- Serves any stored round key combinationally, selected by the core's desired_round index.

---
 rtl/aes_key_expansion.sv | 126 ++++++++++++
 tb/tb_aes_key_expansion.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expansion.sv
// AES-128 key schedule: captures a cipher key on start, derives round keys 1..10 one per clock,
// stores all eleven, and serves any of them combinationally by round index.
module aes_key_expansion #(
    parameter int NR = 10,
    parameter int KW = 128
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [KW-1:0] key_in,
    input  logic [3:0]    desired_round,
    output logic [KW-1:0] round_key,
    output logic          key_expansion_done,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, DONE = 2'd2} state_t;

    localparam logic [3:0] LAST = 4'(NR);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    state_t        state, next_state;
    logic [3:0]    cnt;
    logic [KW-1:0] rk [NR+1];

    logic          capture, step, last;
    logic [KW-1:0] prev_key, new_key;
    logic [31:0]   rot, sub, t, n0, n1, n2, n3;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = EXPAND;
            EXPAND:  if (cnt == LAST) next_state = DONE;
            DONE:    if (start) next_state = EXPAND;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        capture = start && (state != EXPAND);
        step    = (state == EXPAND);
        last    = step && (cnt == LAST);
    end

    // One round of the schedule: four S-box lookups shared across all rounds.
    always_comb begin
        prev_key = (cnt != 4'd0 && cnt <= LAST) ? rk[cnt - 4'd1] : '0;
        rot      = {prev_key[23:0], prev_key[31:24]};
        sub      = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
        t        = sub ^ {rcon(cnt), 24'h0};
        n0       = prev_key[127:96] ^ t;
        n1       = prev_key[95:64]  ^ n0;
        n2       = prev_key[63:32]  ^ n1;
        n3       = prev_key[31:0]   ^ n2;
        new_key  = {n0, n1, n2, n3};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= 4'd0;
            for (int i = 0; i <= NR; i++) rk[i] <= '0;
        end else if (capture) begin
            rk[0] <= key_in;
            cnt   <= 4'd1;
        end else if (step) begin
            rk[cnt] <= new_key;
            if (!last) cnt <= cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy               <= 1'b0;
            key_expansion_done <= 1'b0;
        end else if (capture) begin
            busy               <= 1'b1;
            key_expansion_done <= 1'b0;
        end else if (last) begin
            busy               <= 1'b0;
            key_expansion_done <= 1'b1;
        end
    end

    assign round_key = (desired_round <= LAST) ? rk[desired_round] : '0;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion: FIPS-197 vectors, random keys against a
// word-oriented key schedule model with an algebraically derived S-box, and corner sequences.
module tb_aes_key_expansion;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [127:0] key_in, round_key;
    logic [3:0]   desired_round;
    logic         key_expansion_done, busy;

    int errors = 0;
    int checks = 0;
    logic [127:0] model_rk [11];

    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    aes_key_expansion dut (
        .clk(clk), .reset(reset), .start(start), .key_in(key_in),
        .desired_round(desired_round), .round_key(round_key),
        .key_expansion_done(key_expansion_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        logic [3:0]   idx;
        logic [127:0] exp;
    } vec_t;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    // S-box from the definition: multiplicative inverse in GF(2^8) followed by the affine map.
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        logic [7:0] s;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    task automatic compute_model(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_ref(tmp[31:24]), sbox_ref(tmp[23:16]), sbox_ref(tmp[15:8]), sbox_ref(tmp[7:0])};
                tmp ^= {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic read_rk(input int idx, output logic [127:0] val);
        desired_round = 4'(idx);
        #1;
        val = round_key;
    endtask

    // Called #1 after a rising edge; returns cycles from capture edge to done (0 = timed out).
    task automatic run_expansion(input logic [127:0] key, input int inject, output int lat);
        start  = 1'b1;
        key_in = key;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_at_capture", 128'(busy), 128'd1);
        chk("done_at_capture", 128'(key_expansion_done), 128'd0);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (key_expansion_done) begin
                lat = n;
                break;
            end
            if (n == inject) begin
                start  = 1'b1;
                key_in = 128'h0;
            end
        end
        chk("done_latency", 128'(lat), 128'd10);
        chk("busy_after_done", 128'(busy), 128'd0);
    endtask

    task automatic check_all_vs_model(input string nm);
        logic [127:0] v;
        for (int r = 0; r < 11; r++) begin
            read_rk(r, v);
            chk(nm, v, model_rk[r]);
        end
    endtask

    initial begin
        vec_t vecs [4];
        logic [127:0] v, rkey;
        logic [127:0] last_key;
        int lat;

        vecs[0] = '{KEY_A1, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[1] = '{KEY_A1, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2] = '{KEY_A1, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[3] = '{128'h000102030405060708090a0b0c0d0e0f, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5};

        reset = 1'b0; start = 1'b0; key_in = '0; desired_round = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_done", 128'(key_expansion_done), 128'd0);
        for (int r = 0; r < 16; r++) begin
            read_rk(r, v);
            chk("reset_rk", v, 128'h0);
        end

        // FIPS-197 vectors; the second key is a re-key straight from DONE.
        last_key = 'x;
        for (int i = 0; i < 4; i++) begin
            if (vecs[i].key !== last_key) begin
                run_expansion(vecs[i].key, 0, lat);
                last_key = vecs[i].key;
            end
            read_rk(int'(vecs[i].idx), v);
            chk("fips_vector", v, vecs[i].exp);
        end

        // Start pulse mid-expansion must be ignored.
        run_expansion(KEY_A1, 4, lat);
        read_rk(10, v);
        chk("busy_start_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_rk(0, v);
        chk("busy_start_rk0", v, KEY_A1);

        for (int r = 11; r < 16; r++) begin
            read_rk(r, v);
            chk("out_of_range_rk", v, 128'h0);
            chk("out_of_range_done", 128'(key_expansion_done), 128'd1);
        end

        for (int k = 0; k < 4; k++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            compute_model(rkey);
            run_expansion(rkey, 0, lat);
            check_all_vs_model("random_key_rk");
        end

        // Reset abandons an expansion in progress.
        start = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("midreset_busy", 128'(busy), 128'd0);
        chk("midreset_done", 128'(key_expansion_done), 128'd0);
        for (int r = 0; r < 16; r++) begin
            read_rk(r, v);
            chk("midreset_rk", v, 128'h0);
        end
        rkey = {$urandom, $urandom, $urandom, $urandom};
        compute_model(rkey);
        run_expansion(rkey, 0, lat);
        check_all_vs_model("post_reset_rk");

        // Reset and start on the same edge: reset wins, nothing captured.
        start = 1'b1; reset = 1'b0; key_in = KEY_A1;
        @(posedge clk); #1;
        start = 1'b0; reset = 1'b1;
        chk("collide_busy", 128'(busy), 128'd0);
        chk("collide_done", 128'(key_expansion_done), 128'd0);
        read_rk(0, v);
        chk("collide_rk0", v, 128'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("collide_idle_busy", 128'(busy), 128'd0);
        read_rk(0, v);
        chk("collide_idle_rk0", v, 128'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
